// File: rtl/subservient_dbg_loader.sv
// subservient_dbg_loader: streams a length-prefixed firmware image into a core's SRAM over the debug Wishbone port, then releases debug mode.
// Optional DBG_LOADER_VERIFY_EN reads back every written word and errors on mismatch.
module subservient_dbg_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_debug_mode,
  output logic        o_done,
  output logic        o_err,
  output logic [8:0]  o_words
);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
  typedef enum logic [2:0] {
    HDR0, HDR1, COLLECT, WRITE, DONE, ERR
`ifdef DBG_LOADER_VERIFY_EN
    , READ
`endif
  } state_t;
  state_t state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [8:0] words_q, words_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [23:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;
  logic stb_q, stb_d, we_q, we_d;
  logic rdy_q, dbg_q, done_q, err_q;
  logic xfer, last;
  logic [15:0] hdr;
  assign xfer = i_byte_valid && rdy_q;
  assign last = {7'd0, words_q} + 16'd1 == n_q;
  assign hdr = {i_byte, n_q[7:0]};
`ifndef DBG_LOADER_VERIFY_EN
  logic unused_rdt;
  assign unused_rdt = ^i_wb_rdt;
`endif
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    words_d = words_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sh_d = sh_q;
    idx_d = idx_q;
    stb_d = stb_q;
    we_d = we_q;
    case (state_q)
      HDR0: if (xfer) begin
        n_d[7:0] = i_byte;
        state_d = HDR1;
      end
      HDR1: if (xfer) begin
        n_d[15:8] = i_byte;
        state_d = hdr == 16'd0 ? DONE : hdr > MAX_N ? ERR : COLLECT;
      end
      COLLECT: if (xfer) begin
        idx_d = idx_q + 2'd1;
        sh_d = {i_byte, sh_q[23:8]};
        if (idx_q == 2'd3) begin
          dat_d = {i_byte, sh_q};
          stb_d = 1'b1;
          we_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: if (i_wb_ack) begin
        stb_d = 1'b0;
        we_d = 1'b0;
`ifdef DBG_LOADER_VERIFY_EN
        state_d = READ;
`else
        words_d = words_q + 9'd1;
        adr_d = adr_q + 32'd4;
        state_d = last ? DONE : COLLECT;
`endif
      end
`ifdef DBG_LOADER_VERIFY_EN
      // Idle one cycle after the write ack, then issue the readback on the same address.
      READ: if (!stb_q) stb_d = 1'b1;
      else if (i_wb_ack) begin
        stb_d = 1'b0;
        words_d = i_wb_rdt == dat_q ? words_q + 9'd1 : words_q;
        adr_d = i_wb_rdt == dat_q ? adr_q + 32'd4 : adr_q;
        state_d = i_wb_rdt != dat_q ? ERR : last ? DONE : COLLECT;
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HDR0;
      n_q <= '0;
      words_q <= '0;
      adr_q <= BASE_ADDR;
      dat_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      stb_q <= 1'b0;
      we_q <= 1'b0;
      rdy_q <= 1'b0;
      dbg_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      words_q <= words_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      stb_q <= stb_d;
      we_q <= we_d;
      rdy_q <= state_d inside {HDR0, HDR1, COLLECT};
      dbg_q <= state_d != DONE;
      done_q <= state_d == DONE;
      err_q <= state_d == ERR;
    end
  end
  assign o_byte_ready = rdy_q;
  assign o_wb_adr = adr_q;
  assign o_wb_dat = dat_q;
  assign o_wb_sel = 4'hF;
  assign o_wb_we = we_q;
  assign o_wb_stb = stb_q;
  assign o_debug_mode = dbg_q;
  assign o_done = done_q;
  assign o_err = err_q;
  assign o_words = words_q;
endmodule
